// File: rtl/sm_calc_pkg.sv
// sm_calc_pkg: op encodings, FSM state constants and zero-sign normalisation for sm_calc_seq.
package sm_calc_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_FIN  = 2'd2;
  function automatic logic zsign(input logic s, input logic nz);
    return s & nz;
  endfunction
endpackage

// File: rtl/sm_addsub.sv
// sm_addsub: combinational sign-magnitude add/subtract; sign of the larger magnitude wins.
module sm_addsub #(
  parameter int N = 4
) (
  input  logic         sa,
  input  logic [N-1:0] ma,
  input  logic         sb,
  input  logic [N-1:0] mb,
  output logic         s,
  output logic [N-1:0] m
);
  logic ge;
  assign ge = ma >= mb;
  assign s = (sa == sb || ge) ? sa : sb;
  assign m = (sa == sb) ? ma + mb : ge ? ma - mb : mb - ma;
endmodule

// File: rtl/sm_calc_seq.sv
// sm_calc_seq: multi-cycle sign-magnitude add/sub/mul calculator; SM_CALC_DIV_EN adds restoring divide.
import sm_calc_pkg::*;
module sm_calc_seq #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [2*W-2:0] res,
  output logic         err
);
  localparam int M = W - 1;
  localparam int N = 2 * M;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(M - 1);
  state_t state;
  logic [1:0] op_r;
  logic sa, sb, xa, xb, xs, bad, last;
  logic [M-1:0] ma, mb, ma_n;
  logic [N-1:0] acc, acc_n, xma, xmb, xm;
  logic [N:0] res_n, div_res;
  logic [CW-1:0] cnt;
`ifdef SM_CALC_DIV_EN
  logic [M-1:0] q, q_n;
  logic take;
`endif
  sm_addsub #(.N(N)) u_addsub (.sa(xa), .ma(xma), .sb(xb), .mb(xmb), .s(xs), .m(xm));
  // one adder serves add/sub directly, accumulates partial products, and does the trial subtract
  always_comb begin
    xa = 1'b0;
    xb = 1'b0;
    xma = acc;
    xmb = ma[0] ? N'(mb) << cnt : '0;
    if (!op_r[1]) begin
      xa = sa;
      xb = sb ^ op_r[0];
      xma = N'(ma);
      xmb = N'(mb);
    end
`ifdef SM_CALC_DIV_EN
    if (op_r == OP_DIV) begin
      xb = 1'b1;
      xma = {acc[N-2:0], ma[M-1]};
      xmb = N'(mb);
    end
`endif
  end
  always_comb begin
    acc_n = xm;
    ma_n = ma >> 1;
    div_res = '0;
`ifdef SM_CALC_DIV_EN
    take = !xs;
    q_n = {q[M-2:0], take};
    bad = op_r == OP_DIV && mb == '0;
    if (op_r == OP_DIV) begin
      acc_n = take ? xm : xma;
      ma_n = ma << 1;
    end
    div_res = {zsign(sa ^ sb, |{acc_n[M-1:0], q_n}), acc_n[M-1:0], q_n};
`else
    bad = op_r == OP_DIV;
`endif
    last = !op_r[1] || bad || cnt == LAST;
    res_n = bad ? '0 : !op_r[1] ? {zsign(xs, |xm), xm} :
            op_r == OP_MUL ? {zsign(sa ^ sb, |acc_n), acc_n} : div_res;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      res <= '0;
      err <= 1'b0;
      cnt <= '0;
      acc <= '0;
      op_r <= OP_ADD;
      {sa, ma} <= '0;
      {sb, mb} <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state <= S_CALC;
        op_r <= op;
        {sa, ma} <= a;
        {sb, mb} <= b;
        cnt <= '0;
        acc <= '0;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + CW'(1);
      acc <= acc_n;
      ma <= ma_n;
      if (last) begin
        state <= S_FIN;
        res <= res_n;
        err <= bad;
      end
    end else
      state <= S_IDLE;
  end
`ifdef SM_CALC_DIV_EN
  always_ff @(posedge clk)
    q <= (rst || state == S_IDLE) ? '0 : state == S_CALC ? q_n : q;
`endif
  assign busy = state != S_IDLE;
  assign done = state == S_FIN;
endmodule

// File: tb/tb_sm_calc_seq.sv
// tb_sm_calc_seq: scoreboard bench for sm_calc_seq (W=3) against an integer-arithmetic reference model.
module tb_sm_calc_seq;
  localparam int W = 3;
  localparam int R = 2 * W - 1;
  localparam int RM = R - 1;
  typedef struct {
    logic [R-1:0] res;
    logic err;
    int cyc;
  } exp_t;
  logic clk, rst, start, busy, done, err;
  logic [1:0] op;
  logic [W-1:0] a, b;
  logic [R-1:0] res;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t scb[$];
  sm_calc_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int av, bv, va, vb, mag;
    logic s;
    av = int'(x[W-2:0]);
    bv = int'(y[W-2:0]);
    mag = 0;
    s = 1'b0;
    e.err = 1'b0;
    e.cyc = 2;
    e.res = '0;
    if (o < 2) begin
      va = x[W-1] ? -av : av;
      vb = (y[W-1] ^ o[0]) ? -bv : bv;
      mag = va + vb;
      s = mag < 0;
      if (s) mag = -mag;
    end else if (o == 2) begin
      mag = av * bv;
      s = x[W-1] ^ y[W-1];
      e.cyc = W;
    end else begin
`ifdef SM_CALC_DIV_EN
      if (bv == 0) e.err = 1'b1;
      else begin
        mag = (av % bv) * (1 << (W - 1)) + av / bv;
        s = x[W-1] ^ y[W-1];
        e.cyc = W;
      end
`else
      e.err = 1'b1;
`endif
    end
    if (!e.err) e.res = {s && mag != 0, RM'(mag)};
    return e;
  endfunction
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    e = model(o, x, y);
    e.cyc = cyc + e.cyc;
    scb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask
  task automatic wait_idle();
    int g = 0;
    while (busy && g < 40) begin
      start = $urandom_range(0, 2) == 0;
      op = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      if (scb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = scb.pop_front();
        chk("res", 32'(res), 32'(e.res));
        chk("err", 32'(err), 32'(e.err));
        chk("latency", cyc, e.cyc);
        chk("busy_at_done", 32'(busy), 1);
      end
    end
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 3'b011, 3'b110);
    wait_idle();
    issue(2'b01, 3'b011, 3'b110);
    wait_idle();
    issue(2'b10, 3'b111, 3'b011);
    wait_idle();
    issue(2'b01, 3'b010, 3'b010);
    wait_idle();
    issue(2'b00, 3'b100, 3'b000);
    wait_idle();
    issue(2'b11, 3'b011, 3'b110);
    wait_idle();
    issue(2'b11, 3'b011, 3'b100);
    wait_idle();
    issue(2'b10, 3'b100, 3'b011);
    wait_idle();
    issue(2'b00, 3'b101, 3'b001);
    wait_idle();
    issue(2'b10, 3'b111, 3'b011);
    wait_idle();
    issue(2'b10, 3'b011, 3'b011);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_res", 32'(res), 0);
    chk("midrst_err", 32'(err), 0);
    scb.delete();
    rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 3'b010, 3'b001);
    wait_idle();
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2'($urandom), W'($urandom), W'($urandom));
      wait_idle();
    end
    repeat (4) @(negedge clk);
    if (scb.size() != 0) chk("pending_results", scb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
